// File: rtl/fft_in_packer.sv
// Purpose: packs a serial I/Q sample stream into ping-pong frame banks and replays each full frame as a NUM_IN_OUT-lane burst.
// Latency: first burst beat is registered on the 2nd rising edge after the frame's last accepted sample.
// Backpressure: din_ready drops only while the bank to be written next is still unread; a burst never stalls once started.
module fft_in_packer #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_IN_OUT = 16,
    parameter int FRAME_LEN  = 512
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  din_valid,
    input  logic signed [DATA_WIDTH-1:0]          din_i,
    input  logic signed [DATA_WIDTH-1:0]          din_q,
    output logic                                  din_ready,
    output logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] dout_i,
    output logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] dout_q,
    output logic                                  valid
);

    localparam int BEATS = FRAME_LEN / NUM_IN_OUT;
    localparam int AW    = $clog2(FRAME_LEN);
    localparam int BW    = $clog2(BEATS);
    localparam int LW    = $clog2(NUM_IN_OUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Both banks live in one array; the top address bit selects the bank.
    logic [2*DATA_WIDTH-1:0] mem [2*FRAME_LEN];

    logic [AW-1:0] wr_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    state;
    logic [BW-1:0] beat;

    logic          accept;
    logic          wr_last;
    logic          rd_last;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;

    assign din_ready = ~full[wr_bank];
    assign accept    = din_valid & din_ready;
    assign wr_last   = accept & (wr_cnt == AW'(FRAME_LEN - 1));
    assign rd_last   = (state == S_BURST) && (beat == BW'(BEATS - 1));

    // Decode which bank flags get set by a completed write and cleared by a completed burst.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_last) full_set[wr_bank] = 1'b1;
        if (rd_last) full_clr[rd_bank] = 1'b1;
    end

    // Sample storage; contents survive reset, only the flags are cleared.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[{wr_bank, wr_cnt}] <= {din_i, din_q};
        end
    end

    // Write pointer: advance per accepted sample, wrap and swap banks at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (wr_last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Bank full flags; a release on the same edge as a fill never blocks the writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Read FSM: banks are filled alternately, so rd_bank always names the oldest full bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            beat    <= '0;
            rd_bank <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    beat <= '0;
                    if (full[rd_bank]) state <= S_BURST;
                end
                S_BURST: begin
                    if (rd_last) begin
                        state   <= S_GAP;
                        beat    <= '0;
                        rd_bank <= ~rd_bank;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_GAP: begin
                    beat  <= '0;
                    state <= full[rd_bank] ? S_BURST : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    // Output register: one beat of NUM_IN_OUT consecutive samples per BURST cycle, zeros otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            dout_i <= '0;
            dout_q <= '0;
        end else if (state == S_BURST) begin
            valid <= 1'b1;
            for (int j = 0; j < NUM_IN_OUT; j++) begin
                {dout_i[j], dout_q[j]} <= mem[{rd_bank, beat, LW'(j)}];
            end
        end else begin
            valid  <= 1'b0;
            dout_i <= '0;
            dout_q <= '0;
        end
    end

endmodule

// File: tb/tb_fft_in_packer.sv
// Purpose: randomized scoreboard bench for fft_in_packer against a frame-level reference model.
// Latency: expects each burst to start 2 edges after the frame's last accepted sample.
// Backpressure: stimulus holds a sample until din_ready accepts it; stalls are counted.
module tb_fft_in_packer;

    localparam int DW = 9;
    localparam int NL = 16;
    localparam int FL = 512;
    localparam int NB = FL / NL;

    typedef struct packed {
        logic [NL-1:0][DW-1:0] i;
        logic [NL-1:0][DW-1:0] q;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  din_valid = 1'b0;
    logic signed [DW-1:0]  din_i = '0;
    logic signed [DW-1:0]  din_q = '0;
    logic                  din_ready;
    logic [NL-1:0][DW-1:0] dout_i;
    logic [NL-1:0][DW-1:0] dout_q;
    logic                  valid;

    fft_in_packer #(.DATA_WIDTH(DW), .NUM_IN_OUT(NL), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_i     (din_i),
        .din_q     (din_q),
        .din_ready (din_ready),
        .dout_i    (dout_i),
        .dout_q    (dout_q),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    int    exp_start[$];
    int    part_i[$];
    int    part_q[$];
    int    stalls = 0;
    bit    abort = 1'b0;

    task automatic chk(input string name, input logic [2*NL*DW-1:0] act, input logic [2*NL*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: collect accepted samples; a completed frame becomes NB beats of NL consecutive samples.
    task automatic model_accept(input int si, input int sq, input int edge_no);
        part_i.push_back(si);
        part_q.push_back(sq);
        if (part_i.size() == FL) begin
            for (int k = 0; k < NB; k++) begin
                beat_t b;
                for (int j = 0; j < NL; j++) begin
                    b.i[j] = DW'(part_i[k*NL + j]);
                    b.q[j] = DW'(part_q[k*NL + j]);
                end
                exp_q.push_back(b);
            end
            exp_start.push_back(edge_no + 2);
            part_i.delete();
            part_q.delete();
        end
    endtask

    // Offer one sample until accepted; entered and left just after a rising edge.
    task automatic send(input int si, input int sq);
        int guard;
        bit acc;
        int e;
        guard = 0;
        acc = 1'b0;
        e = 0;
        din_valid = 1'b1;
        din_i = DW'(si);
        din_q = DW'(sq);
        while (!acc) begin
            @(negedge clk);
            acc = din_ready;
            e = cyc + 1;
            if (!din_ready) stalls++;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                $display("FAIL send: din_ready held low for %0d cycles", guard);
                $fatal(1);
            end
        end
        model_accept(si, sq, e);
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 ramp, 1 random data. vmode: 0 continuous, 1 toggling 1/0, 2 random gaps.
    task automatic frame(input int nsamp, input int kind, input int vmode);
        int si;
        int sq;
        for (int n = 0; n < nsamp; n++) begin
            if (kind == 0) begin
                si = n - 256;
                sq = 255 - n;
            end else begin
                si = int'($urandom_range(0, 511)) - 256;
                sq = int'($urandom_range(0, 511)) - 256;
            end
            send(si, sq);
            if (vmode == 1) idle(1);
            else if (vmode == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic flush_model();
        part_i.delete();
        part_q.delete();
        exp_q.delete();
        exp_start.delete();
        abort = 1'b1;
    endtask

    // Monitor: compare every valid beat with the scoreboard; check burst length, start cycle and idle zeros.
    initial begin
        int    run;
        beat_t got;
        run = 0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (run == 0) begin
                    chk("burst_expected", exp_start.size() != 0, 1'b1);
                    if (exp_start.size() != 0) chk("burst_start_cycle", cyc, exp_start.pop_front());
                end
                got = {dout_i, dout_q};
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk($sformatf("beat%0d_data", run), got, exp_q.pop_front());
                run++;
            end else begin
                chk("valid_low_known", valid, 1'b0);
                chk("lanes_zero_when_idle", {dout_i, dout_q}, '0);
                if (run != 0 && !abort) chk("burst_length", run, NB);
                abort = 1'b0;
                run = 0;
            end
        end
    end

    initial begin
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", valid, 1'b0);
        chk("reset_din_ready", din_ready, 1'b1);
        chk("reset_lanes", {dout_i, dout_q}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();

        // Single ramp frame, continuous valid
        stalls = 0;
        frame(FL, 0, 0);
        idle(40);
        chk("ramp_no_stall", stalls, 0);

        // Three back-to-back frames
        stalls = 0;
        frame(FL, 0, 0);
        frame(FL, 1, 0);
        frame(FL, 1, 0);
        idle(40);
        chk("b2b_no_stall", stalls, 0);

        // 50% toggling valid ramp
        frame(FL, 0, 1);
        idle(40);

        // Reset after a partial frame, then a fresh ramp
        frame(300, 1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        frame(FL, 0, 0);
        idle(40);

        // Reset during burst beat 10
        frame(FL, 1, 0);
        seen = 0;
        for (int t = 0; t < 100 && seen < 11; t++) begin
            if (valid === 1'b1) seen++;
            if (seen < 11) begin
                @(posedge clk);
                #1;
            end
        end
        chk("beat10_reached", seen, 11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        chk("valid_after_midburst_reset", valid, 1'b0);
        chk("lanes_after_midburst_reset", {dout_i, dout_q}, '0);
        idle(40);
        frame(FL, 1, 0);
        idle(40);

        // Random data with random input gaps
        frame(FL, 1, 2);
        frame(FL, 1, 2);

        for (int t = 0; t < 300 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        idle(5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
